alu_op_sequencer: RTL and testbench

- Front-end stage between the system bus and the one-hot ALU control unit/datapath.
- Accepts one operation request at a time over a valid/ready handshake and pulses BEGIN with the op code.
- Drives INBUS with the correct operand whenever the control unit sits in a load state.
- Captures OUTBUS words during the push states and returns the assembled result over a second valid/ready handshake.

---
 rtl/alu_op_sequencer_if.sv | 39 +++
 rtl/alu_op_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request, control-unit and response signal bundle for alu_op_sequencer
//   master : sequencer side, drives req_ready, cu_begin, cu_op_code, inbus, rsp_valid/hi/lo/err
//   slave  : requester / control unit / consumer side, drives everything else
interface alu_op_sequencer_if #(
    parameter int W = 8
) ();
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_q;
    logic [W-1:0] req_m;
    logic         cu_begin;
    logic [1:0]   cu_op_code;
    logic         cu_ld_a;
    logic         cu_ld_q;
    logic         cu_ld_m;
    logic [W-1:0] inbus;
    logic         cu_push_a;
    logic         cu_push_q;
    logic [W-1:0] outbus;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_hi;
    logic [W-1:0] rsp_lo;
    logic         rsp_err;

    modport master (
        input  req_valid, req_op, req_a, req_q, req_m,
        input  cu_ld_a, cu_ld_q, cu_ld_m, cu_push_a, cu_push_q, outbus, rsp_ready,
        output req_ready, cu_begin, cu_op_code, inbus, rsp_valid, rsp_hi, rsp_lo, rsp_err
    );

    modport slave (
        output req_valid, req_op, req_a, req_q, req_m,
        output cu_ld_a, cu_ld_q, cu_ld_m, cu_push_a, cu_push_q, outbus, rsp_ready,
        input  req_ready, cu_begin, cu_op_code, inbus, rsp_valid, rsp_hi, rsp_lo, rsp_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: bus front-end that starts the one-hot ALU control unit, feeds operands, collects results
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : alu_op_sequencer_if.master (request handshake, control-unit strobes, response handshake)
//   Optional: define ALU_WATCHDOG_EN to abort LOAD/RUN after TIMEOUT_CYCLES with rsp_err=1.
module alu_op_sequencer #(
    parameter int W              = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                clk,
    input logic                reset,
    alu_op_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, START, LOAD, RUN, RESP} state_t;

    state_t       state_q, state_d;
    logic [1:0]   op_q, op_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [1:0]   need;
    logic [W-1:0] a_q, a_d, q_q, q_d, m_q, m_d;
    logic [W-1:0] hi_q, hi_d, lo_q, lo_d;
`ifdef ALU_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // add/sub return one word, mul/div return two
    assign need = op_q[1] ? 2'd2 : 2'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef ALU_WATCHDOG_EN
            wd_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef ALU_WATCHDOG_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                op_d    = bus.req_op;
                a_d     = bus.req_a;
                q_d     = bus.req_q;
                m_d     = bus.req_m;
                hi_d    = '0;
                lo_d    = '0;
                cnt_d   = '0;
                state_d = START;
            end
            START: state_d = LOAD;
            LOAD: if (bus.cu_ld_m) state_d = RUN;
            RUN: begin
                if (bus.cu_push_a) hi_d = bus.outbus;
                if (bus.cu_push_q) lo_d = bus.outbus;
                // simultaneous pushes count as two
                cnt_d = cnt_q + {1'b0, bus.cu_push_a} + {1'b0, bus.cu_push_q};
                if (cnt_d >= need) state_d = RESP;
            end
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef ALU_WATCHDOG_EN
        err_d = err_q;
        if (state_q == RESP && bus.rsp_ready) err_d = 1'b0;
        // counts LOAD/RUN cycles; zero everywhere else so it is clear on entering START
        wd_d = (state_q == LOAD || state_q == RUN) ? wd_q + 1'b1 : '0;
        if (wd_d == CW'(TIMEOUT_CYCLES)) begin
            state_d = RESP;
            hi_d    = '0;
            lo_d    = '0;
            err_d   = 1'b1;
        end
`endif
    end

    always_comb begin
        bus.req_ready  = state_q == IDLE;
        bus.cu_begin   = state_q == START;
        bus.cu_op_code = state_q == IDLE ? 2'b00 : op_q;
        bus.inbus      = state_q != LOAD ? '0 :
                         bus.cu_ld_a     ? a_q :
                         bus.cu_ld_q     ? q_q :
                         bus.cu_ld_m     ? m_q : '0;
        bus.rsp_valid  = state_q == RESP;
        bus.rsp_hi     = hi_q;
        bus.rsp_lo     = lo_q;
`ifdef ALU_WATCHDOG_EN
        bus.rsp_err    = err_q;
`else
        bus.rsp_err    = 1'b0;
`endif
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed table, corner sequences and random ops checked against an arithmetic model
module tb_alu_op_sequencer;
    localparam int W  = 8;
    localparam int TO = 20;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.W(W)) bus ();
    alu_op_sequencer #(.W(W), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, q, m, hi, lo;
        int           bp;
    } vec_t;

    vec_t tbl [6];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset(input string n);
        chk({n, " req_ready"}, bus.req_ready, 1);
        chk({n, " cu_begin"}, bus.cu_begin, 0);
        chk({n, " cu_op_code"}, bus.cu_op_code, 0);
        chk({n, " inbus"}, bus.inbus, 0);
        chk({n, " rsp_valid"}, bus.rsp_valid, 0);
        chk({n, " rsp_hi"}, bus.rsp_hi, 0);
        chk({n, " rsp_lo"}, bus.rsp_lo, 0);
        chk({n, " rsp_err"}, bus.rsp_err, 0);
    endtask

    // arithmetic reference: what the datapath returns for each op
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, q, m,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo);
        logic [2*W-1:0] p;
        p = '0;
        case (op)
            2'b00: begin hi = a + m; lo = '0; end
            2'b01: begin hi = a - m; lo = '0; end
            2'b10: begin p = q * m; hi = p[2*W-1:W]; lo = p[W-1:0]; end
            default: begin p = {a, q}; lo = W'(p / {{W{1'b0}}, m}); hi = W'(p % {{W{1'b0}}, m}); end
        endcase
    endfunction

    task automatic start(input logic [1:0] op, input logic [W-1:0] a, q, m);
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_q     = q;
        bus.req_m     = m;
        bus.req_valid = 1'b1;
        #1 chk("req_ready idle", bus.req_ready, 1);
        cyc();
        bus.req_valid = 1'b0;
        bus.req_a     = W'($urandom);
        bus.req_q     = W'($urandom);
        bus.req_m     = W'($urandom);
        bus.req_op    = 2'($urandom);
        #1 chk("cu_begin", bus.cu_begin, 1);
        chk("cu_op_code", bus.cu_op_code, op);
        chk("req_ready busy", bus.req_ready, 0);
        cyc();
        #1 chk("cu_begin one cycle", bus.cu_begin, 0);
        chk("cu_op_code held", bus.cu_op_code, op);
    endtask

    task automatic load(input logic la, lq, lm, input logic [W-1:0] exp, input string n);
        bus.cu_ld_a = la;
        bus.cu_ld_q = lq;
        bus.cu_ld_m = lm;
        #1 chk(n, bus.inbus, exp);
        cyc();
        bus.cu_ld_a = 1'b0;
        bus.cu_ld_q = 1'b0;
        bus.cu_ld_m = 1'b0;
    endtask

    task automatic push(input logic pa, pq, input logic [W-1:0] v);
        bus.cu_push_a = pa;
        bus.cu_push_q = pq;
        bus.outbus    = v;
        cyc();
        bus.cu_push_a = 1'b0;
        bus.cu_push_q = 1'b0;
        bus.outbus    = W'($urandom);
    endtask

    // LOAD-phase idle cycles with stray push strobes that must be ignored
    task automatic gap_load(input int n);
        for (int i = 0; i < n; i++) begin
            bus.cu_push_a = 1'($urandom);
            bus.cu_push_q = 1'($urandom);
            bus.outbus    = W'($urandom);
            #1 chk("inbus idle in LOAD", bus.inbus, 0);
            cyc();
        end
        bus.cu_push_a = 1'b0;
        bus.cu_push_q = 1'b0;
    endtask

    // RUN-phase idle cycles with stray load strobes that must leave inbus at 0
    task automatic gap_run(input int n);
        for (int i = 0; i < n; i++) begin
            bus.cu_ld_a = 1'($urandom);
            bus.cu_ld_q = 1'($urandom);
            bus.cu_ld_m = 1'($urandom);
            #1 chk("inbus outside LOAD", bus.inbus, 0);
            chk("no early rsp_valid", bus.rsp_valid, 0);
            cyc();
        end
        bus.cu_ld_a = 1'b0;
        bus.cu_ld_q = 1'b0;
        bus.cu_ld_m = 1'b0;
    endtask

    task automatic resp(input logic [W-1:0] hi, lo, input logic err, input int bp);
        #1 chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_hi", bus.rsp_hi, hi);
        chk("rsp_lo", bus.rsp_lo, lo);
        chk("rsp_err", bus.rsp_err, err);
        chk("req_ready in RESP", bus.req_ready, 0);
        for (int i = 0; i < bp; i++) begin
            bus.rsp_ready = 1'b0;
            bus.req_valid = 1'b1;
            bus.req_op    = 2'($urandom);
            cyc();
            #1 chk("rsp_valid held", bus.rsp_valid, 1);
            chk("rsp_hi held", bus.rsp_hi, hi);
            chk("rsp_lo held", bus.rsp_lo, lo);
            chk("req_ready held low", bus.req_ready, 0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        cyc();
        bus.rsp_ready = 1'b0;
        #1 chk("rsp_valid dropped", bus.rsp_valid, 0);
        chk("req_ready after rsp", bus.req_ready, 1);
        chk("rsp_err cleared", bus.rsp_err, 0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, q, m, hi, lo, input int bp);
        start(op, a, q, m);
        if (op != 2'b10) begin
            gap_load($urandom_range(0, 2));
            load(1'b1, 1'b0, 1'b0, a, "inbus A");
        end
        if (op[1]) begin
            gap_load($urandom_range(0, 2));
            load(1'b0, 1'b1, 1'b0, q, "inbus Q");
        end
        gap_load($urandom_range(0, 2));
        load(1'b0, 1'b0, 1'b1, m, "inbus M");
        if (op == 2'b11) begin
            gap_run($urandom_range(0, 2));
            push(1'b0, 1'b1, lo);
        end
        gap_run($urandom_range(0, 2));
        push(1'b1, 1'b0, hi);
        if (op == 2'b10) begin
            gap_run($urandom_range(0, 2));
            push(1'b0, 1'b1, lo);
        end
        resp(hi, lo, 1'b0, bp);
    endtask

    initial begin
        logic [1:0]   op;
        logic [W-1:0] a, q, m, hi, lo;
        int           j;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_a     = '0;
        bus.req_q     = '0;
        bus.req_m     = '0;
        bus.cu_ld_a   = 1'b0;
        bus.cu_ld_q   = 1'b0;
        bus.cu_ld_m   = 1'b0;
        bus.cu_push_a = 1'b0;
        bus.cu_push_q = 1'b0;
        bus.outbus    = '0;
        bus.rsp_ready = 1'b0;
        tbl[0] = '{op: 2'b00, a: 8'h12, q: 8'h00, m: 8'h05, hi: 8'h17, lo: 8'h00, bp: 0};
        tbl[1] = '{op: 2'b10, a: 8'h00, q: 8'h07, m: 8'h06, hi: 8'h00, lo: 8'h2A, bp: 1};
        tbl[2] = '{op: 2'b11, a: 8'h00, q: 8'h64, m: 8'h07, hi: 8'h02, lo: 8'h0E, bp: 0};
        tbl[3] = '{op: 2'b01, a: 8'h10, q: 8'h99, m: 8'h30, hi: 8'hE0, lo: 8'h00, bp: 2};
        tbl[4] = '{op: 2'b11, a: 8'h03, q: 8'hE8, m: 8'h10, hi: 8'h08, lo: 8'h3E, bp: 10};
        tbl[5] = '{op: 2'b00, a: 8'hFF, q: 8'h00, m: 8'h01, hi: 8'h00, lo: 8'h00, bp: 0};

        @(negedge clk);
        #1 chk_reset("reset");
        reset = 1'b1;
        cyc();

        for (int i = 0; i < 6; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].q, tbl[i].m, tbl[i].hi, tbl[i].lo, tbl[i].bp);

        // load priority A > Q > M, then both pushes in one cycle
        start(2'b10, 8'hA1, 8'hB2, 8'hC3);
        load(1'b1, 1'b1, 1'b0, 8'hA1, "prio A over Q");
        load(1'b0, 1'b1, 1'b0, 8'hB2, "load Q alone");
        load(1'b1, 1'b1, 1'b1, 8'hA1, "prio A over Q,M");
        push(1'b1, 1'b1, 8'h5A);
        resp(8'h5A, 8'h5A, 1'b0, 0);

        // reset after the first mul push discards everything
        start(2'b10, 8'h00, 8'hF0, 8'h10);
        load(1'b0, 1'b1, 1'b0, 8'hF0, "inbus Q pre-reset");
        load(1'b0, 1'b0, 1'b1, 8'h10, "inbus M pre-reset");
        push(1'b1, 1'b0, 8'h0F);
        bus.cu_ld_a = 1'b1;
        reset = 1'b0;
        #1 chk_reset("mid-RUN reset");
        cyc();
        bus.cu_ld_a = 1'b0;
        reset = 1'b1;
        cyc();
        run_op(2'b00, 8'h12, 8'h00, 8'h05, 8'h17, 8'h00, 0);

        // div that never pushes
        start(2'b11, 8'h00, 8'h64, 8'h07);
        load(1'b1, 1'b0, 1'b0, 8'h00, "wd inbus A");
        load(1'b0, 1'b1, 1'b0, 8'h64, "wd inbus Q");
        load(1'b0, 1'b0, 1'b1, 8'h07, "wd inbus M");
`ifdef ALU_WATCHDOG_EN
        j = 0;
        #1;
        while (!bus.rsp_valid && j < 100) begin
            cyc();
            #1;
            j++;
        end
        chk("watchdog LOAD/RUN cycles", 3 + j, TO);
        resp(8'h00, 8'h00, 1'b1, 0);
`else
        for (j = 0; j < 40; j++) begin
            cyc();
            #1 chk("no timeout without watchdog", bus.rsp_valid, 0);
        end
        reset = 1'b0;
        #1 chk_reset("recover reset");
        cyc();
        reset = 1'b1;
        cyc();
`endif

        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = W'($urandom);
            q  = W'($urandom);
            m  = W'($urandom);
            if (op == 2'b11) begin
                if (m == 0) m = 8'd1;
                a = a % m;
            end
            model(op, a, q, m, hi, lo);
            run_op(op, a, q, m, hi, lo, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
